// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencer for an in-place radix-2 DIT FFT on a single butterfly.
// Issues one butterfly per cycle per stage (read addresses + twiddle index),
// then drains the memory/butterfly pipeline before the next stage begins.
// bf_en and the write-back strobe/addresses are the read strobe/addresses
// passed through a fixed delay line of MEM_LAT and MEM_LAT+BF_LAT cycles.
//
// Handshake: start is a single-cycle request that is only sampled in IDLE;
// there is no back-pressure. Every rd_en cycle is one issued butterfly, and
// its write-back appears exactly D cycles later. busy covers RUN and DRAIN.
module fft_ctrl #(
  parameter int LOG2N   = 6,
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 3,
  localparam int SW     = $clog2(LOG2N),
  localparam int KW     = LOG2N - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_p,
  output logic [LOG2N-1:0] rd_addr_q,
  output logic [KW-1:0]    tw_addr,
  output logic             bf_en,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_p,
  output logic [LOG2N-1:0] wr_addr_q,
  output logic [1:0]       dbg_state
);

  localparam int D  = MEM_LAT + BF_LAT;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [KW-1:0] k_q;
  logic [SW-1:0] s_q;
  logic [CW-1:0] dcnt;

  logic [D-1:0]     en_pipe;
  logic [LOG2N-1:0] p_pipe [D];
  logic [LOG2N-1:0] q_pipe [D];

  // Ones in the low s bits of k (the position inside a butterfly group).
  function automatic logic [KW-1:0] low_mask(input logic [SW-1:0] s);
    return (KW'(1) << s) - KW'(1);
  endfunction

  // Upper operand: k with a zero inserted at bit position s.
  function automatic logic [LOG2N-1:0] p_of(input logic [KW-1:0] k, input logic [SW-1:0] s);
    logic [LOG2N-1:0] kk;
    logic [LOG2N-1:0] lo;
    kk = {1'b0, k};
    lo = {1'b0, k & low_mask(s)};
    return (((kk >> s) << s) << 1) | lo;
  endfunction

  // Lower operand sits one span above the upper operand.
  function automatic logic [LOG2N-1:0] q_of(input logic [KW-1:0] k, input logic [SW-1:0] s);
    return p_of(k, s) | (LOG2N'(1) << s);
  endfunction

  // Twiddle exponent scaled so stage s steps through N/2^(s+1) spaced roots.
  function automatic logic [KW-1:0] tw_of(input logic [KW-1:0] k, input logic [SW-1:0] s);
    return (k & low_mask(s)) << (KW - int'(s));
  endfunction

  assign stage     = s_q;
  assign dbg_state = state;
  assign bf_en     = en_pipe[MEM_LAT-1];
  assign wr_en     = en_pipe[D-1];
  assign wr_addr_p = p_pipe[D-1];
  assign wr_addr_q = q_pipe[D-1];

  // Control FSM: issues butterflies in RUN, counts D drain cycles per stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      s_q       <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_p <= '0;
      rd_addr_q <= '0;
      tw_addr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            k_q       <= '0;
            s_q       <= '0;
            rd_en     <= 1'b1;
            rd_addr_p <= p_of('0, '0);
            rd_addr_q <= q_of('0, '0);
            tw_addr   <= tw_of('0, '0);
          end
        end
        RUN: begin
          if (k_q == {KW{1'b1}}) begin
            state <= DRAIN;
            rd_en <= 1'b0;
            dcnt  <= '0;
          end else begin
            k_q       <= k_q + KW'(1);
            rd_addr_p <= p_of(k_q + KW'(1), s_q);
            rd_addr_q <= q_of(k_q + KW'(1), s_q);
            tw_addr   <= tw_of(k_q + KW'(1), s_q);
          end
        end
        DRAIN: begin
          if (dcnt == CW'(D - 1)) begin
            if (s_q == SW'(LOG2N - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              s_q       <= s_q + SW'(1);
              k_q       <= '0;
              rd_en     <= 1'b1;
              rd_addr_p <= p_of('0, s_q + SW'(1));
              rd_addr_q <= q_of('0, s_q + SW'(1));
              tw_addr   <= tw_of('0, s_q + SW'(1));
            end
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Delay lines aligning butterfly enable and write-back with the reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe <= '0;
      for (int i = 0; i < D; i++) begin
        p_pipe[i] <= '0;
        q_pipe[i] <= '0;
      end
    end else begin
      en_pipe[0] <= rd_en;
      p_pipe[0]  <= rd_addr_p;
      q_pipe[0]  <= rd_addr_q;
      for (int i = 1; i < D; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        p_pipe[i]  <= p_pipe[i-1];
        q_pipe[i]  <= q_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl: an 8-point instance checked cycle by cycle against a
// timeline model, and a 64-point instance driving a memory + butterfly model.
`timescale 1ns/1ps
module tb_fft_ctrl;
  localparam int L3 = 3, N3 = 8, H3 = 4, ML = 1, BL = 3, D = 4;
  localparam int P3 = H3 + D, T3 = L3 * P3;
  localparam int L6 = 6, N6 = 64, H6 = 32, T6 = L6 * (H6 + D);
  localparam real PI = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0, rst = 1'b1, start3 = 1'b0, start6 = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       busy3, done3, rd3, bf3, wr3;
  logic [1:0] stage3, tw3, dbg3;
  logic [2:0] rp3, rq3, wp3, wq3;
  logic       busy6, done6, rd6, bf6, wr6;
  logic [2:0] stage6;
  logic [1:0] dbg6;
  logic [4:0] tw6;
  logic [5:0] rp6, rq6, wp6, wq6;

  fft_ctrl #(.LOG2N(L3), .MEM_LAT(ML), .BF_LAT(BL)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .stage(stage3),
    .rd_en(rd3), .rd_addr_p(rp3), .rd_addr_q(rq3), .tw_addr(tw3), .bf_en(bf3),
    .wr_en(wr3), .wr_addr_p(wp3), .wr_addr_q(wq3), .dbg_state(dbg3));

  fft_ctrl #(.LOG2N(L6), .MEM_LAT(ML), .BF_LAT(BL)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .busy(busy6), .done(done6), .stage(stage6),
    .rd_en(rd6), .rd_addr_p(rp6), .rd_addr_q(rq6), .tw_addr(tw6), .bf_en(bf6),
    .wr_en(wr6), .wr_addr_p(wp6), .wr_addr_q(wq6), .dbg_state(dbg6));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  function automatic int zeros3();
    return int'({busy3, done3, stage3, rd3, rp3, rq3, tw3, bf3, wr3, wp3, wq3});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- timeline reference model (8-point) ----------------
  task automatic addr_of(input int s, input int k, output int p, output int q, output int tw);
    int span;
    span = 1 << s;
    p  = (k / span) * 2 * span + k % span;
    q  = p + span;
    tw = (k % span) * (N3 / 2) / span;
  endtask

  int c0 = 0, b_p = 0, b_q = 0, b_tw = 0, b_st = 0;
  bit have_run = 1'b0;

  function automatic bit issued(input int t);
    return have_run && t >= 1 && t <= T3 && ((t - 1) % P3) < H3;
  endfunction

  task automatic rd_at(input int t, output int p, output int q, output int tw);
    int j;
    if (!have_run || t < 1) begin
      p = b_p; q = b_q; tw = b_tw;
    end else if (t > T3) begin
      addr_of(L3 - 1, H3 - 1, p, q, tw);
    end else begin
      j = (t - 1) % P3;
      addr_of((t - 1) / P3, (j < H3) ? j : H3 - 1, p, q, tw);
    end
  endtask

  function automatic int stage_at(input int t);
    if (!have_run || t < 1) return b_st;
    if (t > T3) return L3 - 1;
    return (t - 1) / P3;
  endfunction

  // Per-cycle comparison of the 8-point instance against the model.
  always @(negedge clk) begin
    int t, p, q, tw, wp, wq, unused_tw;
    if (rst) begin
      have_run = 1'b0; b_p = 0; b_q = 0; b_tw = 0; b_st = 0;
    end else begin
      t = have_run ? cyc - c0 : 0;
      rd_at(t, p, q, tw);
      rd_at(t - D, wp, wq, unused_tw);
      chk("m_rd_en", int'(rd3), int'(issued(t)));
      chk("m_bf_en", int'(bf3), int'(issued(t - ML)));
      chk("m_wr_en", int'(wr3), int'(issued(t - D)));
      chk("m_busy", int'(busy3), int'(have_run && t >= 1 && t <= T3));
      chk("m_done", int'(done3), int'(have_run && t == T3 + 1));
      chk("m_stage", int'(stage3), stage_at(t));
      chk("m_rd_p", int'(rp3), p);
      chk("m_rd_q", int'(rq3), q);
      chk("m_tw", int'(tw3), tw);
      chk("m_wr_p", int'(wp3), wp);
      chk("m_wr_q", int'(wq3), wq);
      if (start3 && (!have_run || t >= T3 + 2)) begin
        if (have_run) begin
          rd_at(t, b_p, b_q, b_tw);
          b_st = stage_at(t);
        end
        c0 = cyc;
        have_run = 1'b1;
      end
    end
  end

  // ---------------- memory + butterfly model (64-point) ----------------
  real mre[N6], mim[N6];
  int  wcnt[N6];
  logic [11:0] exp_q[$];
  real opr_q[$], opi_q[$], oqr_q[$], oqi_q[$];
  int  otw_q[$];
  int  haz = 0, pair_err = 0;

  always @(negedge clk) begin
    logic [11:0] a;
    real pr, pi, qr, qi, ang, w_r, w_i, tr, ti;
    int tw;
    if (!rst) begin
      if (rd6) begin
        if (wcnt[rp6] != int'(stage6) || wcnt[rq6] != int'(stage6)) haz++;
        exp_q.push_back({rp6, rq6});
        opr_q.push_back(mre[rp6]); opi_q.push_back(mim[rp6]);
        oqr_q.push_back(mre[rq6]); oqi_q.push_back(mim[rq6]);
        otw_q.push_back(int'(tw6));
      end
      if (wr6) begin
        if (exp_q.size() == 0) pair_err++;
        else begin
          a  = exp_q.pop_front();
          pr = opr_q.pop_front(); pi = opi_q.pop_front();
          qr = oqr_q.pop_front(); qi = oqi_q.pop_front();
          tw = otw_q.pop_front();
          if (a != {wp6, wq6}) pair_err++;
          ang = -2.0 * PI * real'(tw) / real'(N6);
          w_r = $cos(ang); w_i = $sin(ang);
          tr = w_r * qr - w_i * qi;
          ti = w_r * qi + w_i * qr;
          mre[wp6] = pr + tr; mim[wp6] = pi + ti;
          mre[wq6] = pr - tr; mim[wq6] = pi - ti;
          wcnt[wp6]++; wcnt[wq6]++;
        end
      end
    end
  end

  function automatic int bitrev6(input int x);
    int r = 0;
    for (int i = 0; i < L6; i++) if (x[i]) r |= 1 << (L6 - 1 - i);
    return r;
  endfunction

  task automatic run_fft6(input int n0);
    int c6, dc;
    bit seen;
    real er, ei;
    for (int i = 0; i < N6; i++) begin mre[i] = 0.0; mim[i] = 0.0; wcnt[i] = 0; end
    mre[bitrev6(n0)] = 1.0;
    exp_q.delete(); opr_q.delete(); opi_q.delete(); oqr_q.delete(); oqi_q.delete(); otw_q.delete();
    haz = 0; pair_err = 0;
    tick(); c6 = cyc; start6 = 1'b1;
    tick(); start6 = 1'b0;
    seen = 1'b0; dc = 0;
    for (int i = 0; i < T6 + 40 && !seen; i++) begin
      @(negedge clk);
      if (done6) begin seen = 1'b1; dc = cyc; end
    end
    chk("fft6_done_seen", int'(seen), 1);
    chk("fft6_latency", dc - c6, T6 + 1);
    chk("fft6_raw_hazards", haz, 0);
    chk("fft6_wr_pairing", pair_err + exp_q.size(), 0);
    for (int k = 0; k < N6; k++) begin
      er =  $cos(2.0 * PI * real'(k * n0) / real'(N6));
      ei = -$sin(2.0 * PI * real'(k * n0) / real'(N6));
      checks++;
      if ((mre[k] - er) > 1e-6 || (er - mre[k]) > 1e-6 || (mim[k] - ei) > 1e-6 || (ei - mim[k]) > 1e-6) begin
        failures++;
        $display("FAIL fft6_bin n0=%0d k=%0d: got (%f,%f) expected (%f,%f)", n0, k, mre[k], mim[k], er, ei);
      end
    end
  endtask

  // ---------------- directed vector table (8-point) ----------------
  typedef struct {
    int t; bit start; bit rd; int p, q, tw; bit bf; bit wr; int wp, wq; bit done; bit busy; int stage;
  } vec_t;
  vec_t tab[$];

  function automatic vec_t mk(int t, bit st, bit rd, int p, int q, int tw, bit bf, bit wr,
                              int wp, int wq, bit dn, bit bz, int sg);
    vec_t v;
    v.t = t; v.start = st; v.rd = rd; v.p = p; v.q = q; v.tw = tw; v.bf = bf; v.wr = wr;
    v.wp = wp; v.wq = wq; v.done = dn; v.busy = bz; v.stage = sg;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int c0d, c0r, dc;
    bit seen;
    tab.push_back(mk( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk( 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk( 2, 0, 1, 2, 3, 0, 1, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk( 3, 1, 1, 4, 5, 0, 1, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk( 4, 0, 1, 6, 7, 0, 1, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk( 5, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0));
    tab.push_back(mk( 8, 0, 0, 0, 0, 0, 0, 1, 6, 7, 0, 1, 0));
    tab.push_back(mk( 9, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(10, 0, 1, 1, 3, 2, 1, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(11, 0, 1, 4, 6, 0, 1, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(12, 0, 1, 5, 7, 2, 1, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(13, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 1, 1));
    tab.push_back(mk(16, 0, 0, 0, 0, 0, 0, 1, 5, 7, 0, 1, 1));
    tab.push_back(mk(17, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 2));
    tab.push_back(mk(18, 0, 1, 1, 5, 1, 1, 0, 0, 0, 0, 1, 2));
    tab.push_back(mk(19, 0, 1, 2, 6, 2, 1, 0, 0, 0, 0, 1, 2));
    tab.push_back(mk(20, 0, 1, 3, 7, 3, 1, 0, 0, 0, 0, 1, 2));
    tab.push_back(mk(21, 0, 0, 0, 0, 0, 1, 1, 0, 4, 0, 1, 2));
    tab.push_back(mk(24, 0, 0, 0, 0, 0, 0, 1, 3, 7, 0, 1, 2));
    tab.push_back(mk(25, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    tab.push_back(mk(26, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tab.push_back(mk(27, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: everything held at zero.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_zero", zeros3(), 0);
    end

    // Directed 8-point transform with ignored starts in RUN and DONE.
    tick(); c0d = cyc;
    foreach (tab[i]) begin
      while (cyc < c0d + tab[i].t) begin tick(); start3 = 1'b0; end
      start3 = tab[i].start;
      @(negedge clk);
      chk($sformatf("tab%0d_rd_en", tab[i].t), int'(rd3), int'(tab[i].rd));
      chk($sformatf("tab%0d_bf_en", tab[i].t), int'(bf3), int'(tab[i].bf));
      chk($sformatf("tab%0d_wr_en", tab[i].t), int'(wr3), int'(tab[i].wr));
      chk($sformatf("tab%0d_done", tab[i].t), int'(done3), int'(tab[i].done));
      chk($sformatf("tab%0d_busy", tab[i].t), int'(busy3), int'(tab[i].busy));
      chk($sformatf("tab%0d_stage", tab[i].t), int'(stage3), tab[i].stage);
      if (tab[i].rd) begin
        chk($sformatf("tab%0d_pqt", tab[i].t), int'({rp3, rq3, tw3}),
            (tab[i].p << 5) | (tab[i].q << 2) | tab[i].tw);
      end
      if (tab[i].wr) begin
        chk($sformatf("tab%0d_wr_addr", tab[i].t), int'({wp3, wq3}), (tab[i].wp << 3) | tab[i].wq);
      end
    end
    tick(); start3 = 1'b0;

    // Abort by reset at cycle 10, restart at cycle 12.
    tick(); c0r = cyc; start3 = 1'b1;
    tick(); start3 = 1'b0;
    while (cyc < c0r + 10) tick();
    #1 rst = 1'b1;
    #1 chk("abort_async_zero", zeros3(), 0);
    tick(); rst = 1'b0;
    while (cyc < c0r + 12) tick();
    start3 = 1'b1;
    tick(); start3 = 1'b0;
    @(negedge clk);
    chk("restart_first_read", int'({rd3, rp3, rq3, tw3}), (1 << 8) | (0 << 5) | (1 << 2) | 0);
    seen = 1'b0; dc = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done3) begin seen = 1'b1; dc = cyc; end
    end
    chk("restart_done_seen", int'(seen), 1);
    chk("restart_done_cycle", dc - c0r, 37);

    // Random start pulses (many ignored) with occasional asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      tick();
      start3 = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #1 chk("rand_async_zero", zeros3(), 0);
        tick(); rst = 1'b0; start3 = 1'b0;
      end
    end
    tick(); start3 = 1'b0;

    // 64-point transforms of bit-reversed impulses.
    run_fft6(0);
    run_fft6(1);
    run_fft6($urandom_range(2, N6 - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
